// File: rtl/rx_char_decode.sv
// rx_char_decode: decodes received control/data characters into link events, FIFO writes and time-codes
module rx_char_decode (
  input  logic       posedge_clk,
  input  logic       rx_resetn,
  input  logic       ready_control_p,
  input  logic       ready_data_p,
  input  logic [2:0] control_p_r,
  input  logic [8:0] dta_timec_p,
  input  logic       parity_rec_c,
  input  logic       parity_rec_c_gen,
  input  logic       parity_rec_d,
  input  logic       parity_rec_d_gen,
  input  logic       rx_buffer_ready,
  output logic       rx_got_fct,
  output logic       rx_got_null,
  output logic       rx_got_nchar,
  output logic       rx_got_time_code,
  output logic       rx_buffer_write,
  output logic [8:0] rx_buffer_data,
  output logic [7:0] rx_time_out,
  output logic       rx_tick_out,
  output logic       rx_error_parity,
  output logic       rx_error_esc,
  output logic       rx_overflow
);
  typedef enum logic [1:0] {IDLE, RUN, ESC_RUN, ESC_IDLE} state_t;
  state_t state;
  logic chk_en, err, perr, one, fct, esc, wr, unused;
  logic [8:0] wd;
  assign unused = ^{control_p_r[2], dta_timec_p[8]};
  assign err = rx_error_parity | rx_error_esc | rx_overflow;
  assign one = ready_control_p ^ ready_data_p;
  assign perr = chk_en & (ready_control_p ? parity_rec_c != parity_rec_c_gen : parity_rec_d != parity_rec_d_gen);
  assign fct = ready_control_p & (control_p_r[1:0] == 2'b00);
  assign esc = ready_control_p & (control_p_r[1:0] == 2'b11);
  // in RUN every data char and every EOP/EEP becomes a FIFO entry
  assign wr = (state == RUN) & (ready_data_p | (control_p_r[1:0] == 2'b01) | (control_p_r[1:0] == 2'b10));
  assign wd = ready_data_p ? {1'b0, dta_timec_p[7:0]} : {1'b1, 7'd0, control_p_r[1:0] == 2'b10};
  always_ff @(posedge posedge_clk or negedge rx_resetn)
    if (!rx_resetn) begin
      state <= IDLE;
      chk_en <= 1'b0;
      rx_got_fct <= 1'b0;
      rx_got_null <= 1'b0;
      rx_got_nchar <= 1'b0;
      rx_got_time_code <= 1'b0;
      rx_buffer_write <= 1'b0;
      rx_buffer_data <= 9'd0;
      rx_time_out <= 8'd0;
      rx_tick_out <= 1'b0;
      rx_error_parity <= 1'b0;
      rx_error_esc <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      rx_got_fct <= 1'b0;
      rx_got_null <= 1'b0;
      rx_got_nchar <= 1'b0;
      rx_got_time_code <= 1'b0;
      rx_buffer_write <= 1'b0;
      rx_tick_out <= 1'b0;
      if (ready_control_p | ready_data_p) chk_en <= 1'b1;
      if (err) state <= IDLE;
      else if (ready_control_p & ready_data_p) begin
        rx_error_esc <= 1'b1;
        state <= IDLE;
      end else if (one) begin
        if (perr) rx_error_parity <= 1'b1;
        else if (wr) begin
          rx_got_nchar <= 1'b1;
          if (rx_buffer_ready) begin
            rx_buffer_write <= 1'b1;
            rx_buffer_data <= wd;
          end else rx_overflow <= 1'b1;
        end else case (state)
          IDLE: if (esc) state <= ESC_IDLE;
          ESC_IDLE: begin
            rx_got_null <= fct;
            state <= fct ? RUN : IDLE;
          end
          RUN: begin
            rx_got_fct <= fct;
            if (esc) state <= ESC_RUN;
          end
          ESC_RUN: if (fct) begin
            rx_got_null <= 1'b1;
            state <= RUN;
          end else if (ready_data_p) begin
            rx_time_out <= dta_timec_p[7:0];
            rx_tick_out <= 1'b1;
            rx_got_time_code <= 1'b1;
            state <= RUN;
          end else begin
            rx_error_esc <= 1'b1;
            state <= IDLE;
          end
        endcase
      end
    end
endmodule

// File: tb/tb_rx_char_decode.sv
// tb_rx_char_decode: scoreboard bench comparing rx_char_decode against a link-level reference model
module tb_rx_char_decode;
  logic clk = 0;
  logic rx_resetn = 0;
  logic ready_control_p = 0, ready_data_p = 0;
  logic [2:0] control_p_r = 0;
  logic [8:0] dta_timec_p = 0;
  logic parity_rec_c = 0, parity_rec_c_gen = 0, parity_rec_d = 0, parity_rec_d_gen = 0;
  logic rx_buffer_ready = 1;
  logic rx_got_fct, rx_got_null, rx_got_nchar, rx_got_time_code, rx_buffer_write, rx_tick_out;
  logic rx_error_parity, rx_error_esc, rx_overflow;
  logic [8:0] rx_buffer_data;
  logic [7:0] rx_time_out;
  logic [25:0] act;
  logic [25:0] q[$];
  int checks = 0, errors = 0;
  logic m_link, m_esc, m_chk, m_ep, m_ee, m_ov;
  logic [8:0] m_bd;
  logic [7:0] m_to;

  rx_char_decode dut (
    .posedge_clk(clk), .rx_resetn(rx_resetn),
    .ready_control_p(ready_control_p), .ready_data_p(ready_data_p),
    .control_p_r(control_p_r), .dta_timec_p(dta_timec_p),
    .parity_rec_c(parity_rec_c), .parity_rec_c_gen(parity_rec_c_gen),
    .parity_rec_d(parity_rec_d), .parity_rec_d_gen(parity_rec_d_gen),
    .rx_buffer_ready(rx_buffer_ready),
    .rx_got_fct(rx_got_fct), .rx_got_null(rx_got_null), .rx_got_nchar(rx_got_nchar),
    .rx_got_time_code(rx_got_time_code), .rx_buffer_write(rx_buffer_write),
    .rx_buffer_data(rx_buffer_data), .rx_time_out(rx_time_out), .rx_tick_out(rx_tick_out),
    .rx_error_parity(rx_error_parity), .rx_error_esc(rx_error_esc), .rx_overflow(rx_overflow)
  );

  always #5 clk = ~clk;
  assign act = {rx_got_fct, rx_got_null, rx_got_nchar, rx_got_time_code, rx_buffer_write,
                rx_buffer_data, rx_time_out, rx_tick_out, rx_error_parity, rx_error_esc, rx_overflow};

  // link-level model: "linked" = a NULL has been seen, "esc" = an ESC awaits its partner
  task automatic model(output logic [25:0] e);
    logic fct, nul, nch, tc, wr, tick, rc, rd, stuck;
    logic [1:0] code;
    fct = 0; nul = 0; nch = 0; tc = 0; wr = 0; tick = 0;
    rc = ready_control_p; rd = ready_data_p; code = control_p_r[1:0];
    if (!rx_resetn) begin
      m_link = 0; m_esc = 0; m_chk = 0; m_ep = 0; m_ee = 0; m_ov = 0; m_bd = 0; m_to = 0;
    end else begin
      stuck = m_ep | m_ee | m_ov;
      if (!stuck && (rc || rd)) begin
        if (rc && rd) begin m_ee = 1; m_link = 0; m_esc = 0; end
        else if (m_chk && (rc ? parity_rec_c != parity_rec_c_gen : parity_rec_d != parity_rec_d_gen)) m_ep = 1;
        else if (!m_link) begin
          if (m_esc) begin
            if (rc && code == 0) begin nul = 1; m_link = 1; end
            m_esc = 0;
          end else m_esc = rc && code == 3;
        end else if (m_esc) begin
          m_esc = 0;
          if (rc && code == 0) nul = 1;
          else if (rd) begin m_to = dta_timec_p[7:0]; tick = 1; tc = 1; end
          else begin m_ee = 1; m_link = 0; end
        end else if (rc && code == 0) fct = 1;
        else if (rc && code == 3) m_esc = 1;
        else begin
          nch = 1;
          if (rx_buffer_ready) begin
            wr = 1;
            m_bd = rd ? {1'b0, dta_timec_p[7:0]} : (code == 2 ? 9'h101 : 9'h100);
          end else m_ov = 1;
        end
      end
      if (rc || rd) m_chk = 1;
    end
    e = {fct, nul, nch, tc, wr, m_bd, m_to, tick, m_ep, m_ee, m_ov};
  endtask

  task automatic drive(input logic rn, input logic rc, input logic rd, input logic [1:0] code,
                       input logic [7:0] pay, input logic bad, input logic rdy);
    logic [25:0] e;
    @(negedge clk);
    rx_resetn = rn;
    ready_control_p = rc;
    ready_data_p = rd;
    control_p_r = {1'($urandom), code};
    dta_timec_p = {1'($urandom), pay};
    parity_rec_c = 1'($urandom);
    parity_rec_d = 1'($urandom);
    parity_rec_c_gen = rc ? parity_rec_c ^ bad : 1'($urandom);
    parity_rec_d_gen = rd ? parity_rec_d ^ bad : 1'($urandom);
    rx_buffer_ready = rdy;
    model(e);
    q.push_back(e);
    if (!rn) begin
      #1;
      checks++;
      if (act !== 26'd0) begin
        errors++;
        $display("FAIL async_reset got=%h exp=0", act);
      end
    end
  endtask

  task automatic rst();
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
  endtask
  task automatic ctl(input logic [1:0] c, input logic bad = 0, input logic rdy = 1);
    drive(1, 1, 0, c, 8'($urandom), bad, rdy);
  endtask
  task automatic dat(input logic [7:0] p, input logic bad = 0, input logic rdy = 1);
    drive(1, 0, 1, 2'($urandom), p, bad, rdy);
  endtask
  task automatic idle();
    drive(1, 0, 0, 2'($urandom), 8'($urandom), 0, 1'($urandom));
  endtask

  initial forever begin
    logic [25:0] e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got=%h exp=%h", $time, act, e);
      end
    end
  end

  initial begin
    rst();
    idle();
    ctl(0); dat(8'h22); ctl(1);
    ctl(3); ctl(0); idle();
    dat(8'h5A); ctl(1); idle();
    ctl(3); dat(8'h3F); idle();
    ctl(2); ctl(0);
    ctl(3); ctl(1); ctl(0); idle();
    rst();
    ctl(3, 1); ctl(0); dat(8'h77, 1); dat(8'h12); idle();
    rst();
    ctl(3); ctl(0); dat(8'h11, 0, 0); dat(8'h44); ctl(0); idle();
    rst();
    ctl(3); ctl(1); ctl(3); ctl(0); ctl(3); ctl(3); idle();
    rst();
    ctl(3); ctl(0); drive(1, 1, 1, 0, 8'h55, 0, 1); ctl(0); idle();
    rst();
    ctl(3); ctl(0); ctl(3); drive(0, 0, 1, 0, 8'h66, 0, 1); drive(1, 0, 0, 0, 0, 0, 1); dat(8'h66); idle();
    for (int i = 0; i < 3000; i++) begin
      int k;
      k = $urandom_range(0, 99);
      if (i % 150 == 0 || $urandom_range(0, 299) == 0) begin
        drive(0, 0, 0, 0, 0, 0, 1);
        ctl(3); ctl(0);
      end else if (k < 35) idle();
      else if (k < 65) ctl(2'($urandom), $urandom_range(0, 39) == 0, $urandom_range(0, 39) != 0);
      else if (k < 99) dat(8'($urandom), $urandom_range(0, 39) == 0, $urandom_range(0, 39) != 0);
      else drive(1, 1, 1, 2'($urandom), 8'($urandom), 0, 1);
    end
    idle(); idle();
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
